cfu_issue: RTL

CFU_ISSUE -- requirements
Module: cfu_issue

---
 rtl/cfu_issue_if.sv | 42 ++++
 rtl/cfu_issue.sv | 99 +++++++++
 2 files changed

// File: rtl/cfu_issue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfu_issue_if                                                          |
// | Pipeline-side instruction, CFU command/response and writeback bundle. |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
interface cfu_issue_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 11
);
  logic              inst_valid_i;
  logic [CTRL_W-1:0] inst_ctrl_i;
  logic [XLEN-1:0]   rs1_i;
  logic [XLEN-1:0]   rs2_i;
  logic [4:0]        rd_i;
  logic              pipe_stall_o;
  logic              cfu_valid_o;
  logic [CTRL_W-1:0] cfu_ctrl_o;
  logic [XLEN-1:0]   cfu_src1_o;
  logic [XLEN-1:0]   cfu_src2_o;
  logic              cfu_stall_i;
  logic [XLEN-1:0]   cfu_rslt_i;
  logic              wb_valid_o;
  logic [4:0]        wb_rd_o;
  logic [XLEN-1:0]   wb_data_o;
  logic              err_o;

  // Issue unit side
  modport slave (
    input  inst_valid_i, inst_ctrl_i, rs1_i, rs2_i, rd_i, cfu_stall_i, cfu_rslt_i,
    output pipe_stall_o, cfu_valid_o, cfu_ctrl_o, cfu_src1_o, cfu_src2_o,
           wb_valid_o, wb_rd_o, wb_data_o, err_o
  );

  // Pipeline / CFU side
  modport master (
    output inst_valid_i, inst_ctrl_i, rs1_i, rs2_i, rd_i, cfu_stall_i, cfu_rslt_i,
    input  pipe_stall_o, cfu_valid_o, cfu_ctrl_o, cfu_src1_o, cfu_src2_o,
           wb_valid_o, wb_rd_o, wb_data_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/cfu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfu_issue                                                             |
// | Issues one custom-function-unit command, waits for it, writes back.   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module cfu_issue #(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 11,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  cfu_issue_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] c_TIMEOUT = TIMEOUT[7:0];

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_cfu_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [XLEN-1:0]   r_src1;
  logic [XLEN-1:0]   r_src2;
  logic [4:0]        r_rd;
  logic              r_wb_valid;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_err;
  logic              w_accept;

  assign w_accept = (r_state == IDLE) && bus.inst_valid_i && bus.inst_ctrl_i[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_cfu_valid <= 1'b0;
      r_ctrl      <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_rd        <= 5'd0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_cfu_valid <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ctrl      <= bus.inst_ctrl_i;
            r_src1      <= bus.rs1_i;
            r_src2      <= bus.rs2_i;
            r_rd        <= bus.rd_i;
            r_cfu_valid <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (!bus.cfu_stall_i) begin
            r_wb_data  <= bus.cfu_rslt_i;
            r_wb_valid <= 1'b1;
            r_state    <= DONE;
          end else if (r_cnt == c_TIMEOUT) begin
            // A hung CFU still retires the instruction, with zero data and an error flag
            r_wb_data  <= '0;
            r_wb_valid <= 1'b1;
            r_err      <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_cnt   <= 8'd0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stall must rise in the accept cycle itself so the pipeline holds the operands
  assign bus.pipe_stall_o = (r_state == ISSUE) || (r_state == WAIT) || w_accept;
  assign bus.cfu_valid_o  = r_cfu_valid;
  assign bus.cfu_ctrl_o   = r_ctrl;
  assign bus.cfu_src1_o   = r_src1;
  assign bus.cfu_src2_o   = r_src2;
  assign bus.wb_valid_o   = r_wb_valid;
  assign bus.wb_rd_o      = r_rd;
  assign bus.wb_data_o    = r_wb_data;
  assign bus.err_o        = r_err;

endmodule
`default_nettype wire
